// File: rtl/tmem_wctl.sv
// tmem_wctl: write-side controller for the tmem activation buffer.
// Takes signed TanH samples over valid/ready, requantizes each to a signed
// nibble (round half up, saturate to [-8,7]) and writes addresses 0..127 in
// order. The buffer is then held as full until the reader releases it.
// The reader's release strobe is named buf_release because "release" is a
// reserved word in SystemVerilog.

// Requantizer: s = (x + 2^(SHIFT-1)) >>> SHIFT, evaluated one bit wider than
// the sample so the rounding add cannot overflow, then clamped to a nibble.
module tmem_wctl_quant #(
  parameter int IN_W  = 8,
  parameter int SHIFT = 4
) (
  input  logic signed [IN_W-1:0] x,
  output logic        [3:0]      q
);
  localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) <<< (SHIFT-1);
  localparam logic signed [IN_W:0] QMAX = (IN_W+1)'(7);
  localparam logic signed [IN_W:0] QMIN = ~QMAX;  // -8

  logic signed [IN_W:0] xe;
  logic signed [IN_W:0] s;

  // Round, shift and saturate.
  always_comb begin
    xe = {x[IN_W-1], x};
    s  = (xe + HALF) >>> SHIFT;
    q  = s[3:0];
    if (s > QMAX)      q = 4'h7;
    else if (s < QMIN) q = 4'h8;
  end
endmodule

module tmem_wctl #(
  parameter int IN_W  = 8,
  parameter int SHIFT = 4
) (
  input  logic            clock,
  input  logic            reset_b,
  input  logic            start,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [3:0]      data_out,
  output logic [6:0]      wr_addr,
  output logic            wr,
  output logic            full,
  input  logic            buf_release,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, FILL, LAST, FULL} state_t;

  state_t     state;
  logic [6:0] cnt;
  logic [3:0] q;
  logic       acc;

  tmem_wctl_quant #(.IN_W(IN_W), .SHIFT(SHIFT)) u_quant (
    .x (in_data),
    .q (q)
  );

  // Handshake/status decode from registered state only.
  assign in_ready = (state == FILL);
  assign full     = (state == FULL);
  assign busy     = (state == FILL) || (state == LAST);
  assign acc      = in_valid & in_ready;

  // Fill sequencing plus the one-stage registered tmem write port.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state    <= IDLE;
      cnt      <= 7'd0;
      wr       <= 1'b0;
      wr_addr  <= 7'd0;
      data_out <= 4'd0;
    end else begin
      wr <= acc;
      if (acc) begin
        wr_addr  <= cnt;
        data_out <= q;
        cnt      <= cnt + 7'd1;  // rolls to 0 only on the final accept
      end
      case (state)
        IDLE: if (start) begin
          state <= FILL;
          cnt   <= 7'd0;
        end
        FILL: if (acc && cnt == 7'd127) state <= LAST;
        LAST: state <= FULL;
        FULL: if (buf_release) begin
          // release+start together gives a back-to-back refill
          state <= start ? FILL : IDLE;
          cnt   <= 7'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tmem_wctl.sv
// Directed bench for tmem_wctl (IN_W=8, SHIFT=4): table-driven quantization
// vectors streamed through fills, plus hand-written hold/release, back-to-back
// and reset-mid-fill sequences. A negedge monitor checks every write.
module tb_tmem_wctl;
  logic       clock = 1'b0;
  logic       reset_b;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] data_out;
  logic [6:0] wr_addr;
  logic       wr;
  logic       full;
  logic       buf_release;
  logic       busy;

  tmem_wctl #(.IN_W(8), .SHIFT(4)) dut (
    .clock       (clock),
    .reset_b     (reset_b),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_out    (data_out),
    .wr_addr     (wr_addr),
    .wr          (wr),
    .full        (full),
    .buf_release (buf_release),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] x;
    logic [3:0] q;
  } qvec_t;

  qvec_t      qtab[13];
  logic [7:0] stim_x[128];
  logic [3:0] exp_q[128];

  int total = 0;
  int bad   = 0;
  int exp_addr, nwr, first_wr_cyc, last_wr_cyc, sc;
  bit mon_en = 1'b0;
  bit prev_acc = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write monitor: wr must follow an accept by exactly one cycle, and each
  // write must carry the next address and the expected nibble.
  always @(negedge clock) begin
    if (mon_en) begin
      check("wr_follows_accept", int'(wr), int'(prev_acc));
      if (wr) begin
        check("wr_addr", int'(wr_addr), exp_addr);
        if (exp_addr < 128) check("data_out", int'(data_out), int'(exp_q[exp_addr]));
        exp_addr++;
        nwr++;
        if (nwr == 1) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
      end
      prev_acc = in_valid & in_ready;
    end else begin
      prev_acc = 1'b0;
    end
  end

  // One complete fill: start (optionally with release), stream 128 samples,
  // then check the LAST and FULL cycles.
  task automatic do_fill(input bit bubbly, input bit with_rel);
    int idx, guard;
    bit acc;
    exp_addr = 0;
    nwr      = 0;
    start = 1'b1; buf_release = with_rel; sc = cyc;
    @(posedge clock); #1;
    start = 1'b0; buf_release = 1'b0;
    check("fill_busy", int'(busy), 1);
    check("fill_full", int'(full), 0);
    check("fill_ready", int'(in_ready), 1);
    idx = 0; guard = 0;
    while (idx < 128 && guard < 2000) begin
      in_valid = bubbly ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = stim_x[idx];
      acc      = in_valid & in_ready;
      @(posedge clock); #1;
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    check("fill_accepts", idx, 128);
    check("last_ready", int'(in_ready), 0);
    check("last_busy", int'(busy), 1);
    check("last_full", int'(full), 0);
    @(posedge clock); #1;
    check("full_set", int'(full), 1);
    check("full_busy", int'(busy), 0);
    check("write_count", nwr, 128);
    if (!bubbly) begin
      check("first_wr_cycle", first_wr_cyc - sc, 2);
      check("last_wr_cycle", last_wr_cyc - sc, 129);
    end
  endtask

  initial begin
    qtab[0]  = '{8'sd127,  4'h7};
    qtab[1]  = '{-8'sd128, 4'h8};
    qtab[2]  = '{8'sd7,    4'h0};
    qtab[3]  = '{8'sd8,    4'h1};
    qtab[4]  = '{-8'sd9,   4'hF};
    qtab[5]  = '{-8'sd8,   4'h0};
    qtab[6]  = '{8'sd0,    4'h0};
    qtab[7]  = '{-8'sd1,   4'h0};
    qtab[8]  = '{8'sd24,   4'h2};
    qtab[9]  = '{-8'sd24,  4'hF};
    qtab[10] = '{8'sd119,  4'h7};
    qtab[11] = '{-8'sd120, 4'h9};
    qtab[12] = '{8'sd40,   4'h3};

    reset_b = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; buf_release = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", int'(in_ready), 0);
    check("rst_wr", int'(wr), 0);
    check("rst_addr", int'(wr_addr), 0);
    check("rst_data", int'(data_out), 0);
    check("rst_full", int'(full), 0);
    check("rst_busy", int'(busy), 0);
    reset_b = 1'b1;
    @(posedge clock); #1;
    mon_en = 1'b1;

    // Valid ignored in IDLE.
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      check("idle_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;

    // Basic fill: x = 16k mod 256, nibble = k mod 16.
    for (int k = 0; k < 128; k++) begin
      stim_x[k] = 8'(16 * k);
      exp_q[k]  = 4'(k);
    end
    do_fill(1'b0, 1'b0);

    // Hold: valid and start pulses are ignored while full.
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      start    = (i % 2 == 0);
      @(posedge clock); #1;
      check("hold_ready", int'(in_ready), 0);
      check("hold_wr", int'(wr), 0);
      check("hold_full", int'(full), 1);
    end
    start = 1'b0; in_valid = 1'b0;
    buf_release = 1'b1;
    @(posedge clock); #1;
    buf_release = 1'b0;
    check("rel_full", int'(full), 0);
    check("rel_busy", int'(busy), 0);
    check("rel_ready", int'(in_ready), 0);
    buf_release = 1'b1;  // release outside FULL is ignored
    @(posedge clock); #1;
    buf_release = 1'b0;
    check("idle_rel_busy", int'(busy), 0);

    // Quantization corners cycled through a bubbly fill.
    for (int k = 0; k < 128; k++) begin
      stim_x[k] = qtab[k % 13].x;
      exp_q[k]  = qtab[k % 13].q;
    end
    do_fill(1'b1, 1'b0);

    // Back-to-back: release and start together.
    for (int k = 0; k < 128; k++) begin
      stim_x[k] = qtab[(k + 5) % 13].x;
      exp_q[k]  = qtab[(k + 5) % 13].q;
    end
    do_fill(1'b0, 1'b1);

    // Reset after 50 accepts.
    buf_release = 1'b1;
    @(posedge clock); #1;
    buf_release = 1'b0;
    exp_addr = 0; nwr = 0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      in_valid = 1'b1;
      in_data  = stim_x[k];
      @(posedge clock); #1;
    end
    mon_en = 1'b0;
    check("pre_rst_wr", int'(wr), 1);
    check("pre_rst_busy", int'(busy), 1);
    #2 reset_b = 1'b0;
    #1;
    check("arst_wr", int'(wr), 0);
    check("arst_ready", int'(in_ready), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_full", int'(full), 0);
    check("arst_addr", int'(wr_addr), 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_b = 1'b1;
    @(posedge clock); #1;
    mon_en = 1'b1;
    do_fill(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
